// File: rtl/apb_master_ctrl.sv
// APB master controller: one outstanding command at a time, address decode
// to a one-hot pselx, IDLE/SETUP/ACCESS sequencing, wait-state counting,
// pready timeout, and a single response pulse per accepted command.
//
// Handshakes: a command transfers on a rising pclk edge where
// req_valid & req_ready are both 1. req_ready is high only in IDLE.
// rsp_valid is a one-cycle pulse with no backpressure. The rsp_* fields
// hold their values until the next response.
module apb_master_ctrl #(
    parameter int NO_OF_SLAVES   = 1,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SLAVE_SPAN     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    // command port
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,
    // response port
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic [7:0]                rsp_wait_states,
    // APB bus
    output logic [NO_OF_SLAVES-1:0]   pselx,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDRESS_WIDTH-1:0]  paddr,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic [2:0]                pprot,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr,
    // debug view of the FSM state
    output logic [1:0]                fsm_state
);

    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SPAN_LOG = $clog2(SLAVE_SPAN);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]               state;
    logic [CNT_W-1:0]         wait_cnt;
    logic [CNT_W-1:0]         wait_cnt_inc;
    logic [ADDRESS_WIDTH-1:0] req_idx;
    logic                     decode_hit;
    logic [NO_OF_SLAVES-1:0]  decode_sel;

    // Saturate the wait counter to the 8-bit response field.
    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] v);
        logic [31:0] wide;
        wide = 32'(v);
        return (wide > 32'd255) ? 8'hFF : wide[7:0];
    endfunction

    assign req_ready    = (state == ST_IDLE);
    assign fsm_state    = state;
    assign wait_cnt_inc = wait_cnt + CNT_W'(1);

    // Slave index is the address divided by the span; anything past the
    // last slave is a decode miss and never touches the bus.
    assign req_idx    = req_addr >> SPAN_LOG;
    assign decode_hit = (req_idx < ADDRESS_WIDTH'(NO_OF_SLAVES));
    assign decode_sel = NO_OF_SLAVES'(1) << req_idx;

    // FSM, APB drive, wait counting and response capture.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            pselx           <= '0;
            penable         <= 1'b0;
            pwrite          <= 1'b0;
            paddr           <= '0;
            pwdata          <= '0;
            pstrb           <= '0;
            pprot           <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_slverr      <= 1'b0;
            rsp_timeout     <= 1'b0;
            rsp_wait_states <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        pwrite <= req_write;
                        paddr  <= req_addr;
                        pwdata <= req_wdata;
                        pstrb  <= req_write ? req_strb : '0;
                        pprot  <= req_prot;
                        if (decode_hit) begin
                            pselx <= decode_sel;
                            state <= ST_SETUP;
                        end else begin
                            // Decode miss: answer directly with an error.
                            state           <= ST_RESP;
                            rsp_valid       <= 1'b1;
                            rsp_rdata       <= '0;
                            rsp_slverr      <= 1'b1;
                            rsp_timeout     <= 1'b0;
                            rsp_wait_states <= '0;
                        end
                    end
                end

                ST_SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (pready) begin
                        pselx           <= '0;
                        penable         <= 1'b0;
                        state           <= ST_RESP;
                        rsp_valid       <= 1'b1;
                        rsp_rdata       <= (!pwrite && !pslverr) ? prdata : '0;
                        rsp_slverr      <= pslverr;
                        rsp_timeout     <= 1'b0;
                        rsp_wait_states <= sat8(wait_cnt);
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc == CNT_LIMIT) begin
                            // Slave never answered: abort the transfer.
                            pselx           <= '0;
                            penable         <= 1'b0;
                            state           <= ST_RESP;
                            rsp_valid       <= 1'b1;
                            rsp_rdata       <= '0;
                            rsp_slverr      <= 1'b1;
                            rsp_timeout     <= 1'b1;
                            rsp_wait_states <= sat8(wait_cnt_inc);
                        end
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl with four slaves.
// Driver tasks issue commands and play the slave; a monitor pops the
// expected response queue whenever rsp_valid is seen.
module tb_apb_master_ctrl;

    localparam int NS   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TOUT = 16;
    localparam int RW   = 42; // {rdata, slverr, timeout, wait_states}

    logic          pclk;
    logic          preset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic [7:0]    rsp_wait_states;
    logic [NS-1:0] pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic [1:0]    fsm_state;

    logic [RW-1:0] exp_q[$];
    int            checks;
    int            failures;

    apb_master_ctrl #(
        .NO_OF_SLAVES  (NS),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .SLAVE_SPAN    (16),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .pclk           (pclk),
        .preset         (preset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_strb       (req_strb),
        .req_prot       (req_prot),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_slverr     (rsp_slverr),
        .rsp_timeout    (rsp_timeout),
        .rsp_wait_states(rsp_wait_states),
        .pselx          (pselx),
        .penable        (penable),
        .pwrite         (pwrite),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .pstrb          (pstrb),
        .pprot          (pprot),
        .pready         (pready),
        .prdata         (prdata),
        .pslverr        (pslverr),
        .fsm_state      (fsm_state)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [RW-1:0] exp;
        forever begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("rsp_rdata",       64'(rsp_rdata),       64'(exp[41:10]));
                    check("rsp_slverr",      64'(rsp_slverr),      64'(exp[9]));
                    check("rsp_timeout",     64'(rsp_timeout),     64'(exp[8]));
                    check("rsp_wait_states", 64'(rsp_wait_states), 64'(exp[7:0]));
                end
            end
        end
    end

    // Issue one command and act as the slave. waits<0 means never ready.
    // Returns at the negedge of the response cycle.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input logic [31:0] rd, input logic err, input logic [3:0] exp_sel,
                           input logic [RW-1:0] exp_rsp, output int idle_cyc);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        req_prot  = prot;
        idle_cyc  = 0;
        while (!req_ready && idle_cyc < 50) begin
            @(negedge pclk);
            idle_cyc++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp_rsp);
        @(negedge pclk);
        req_valid = 1'b0;
        if (exp_sel == 4'b0000) begin
            check("miss_rsp_valid", 64'(rsp_valid), 64'd1);
            check("miss_pselx",     64'(pselx),     64'd0);
            return;
        end
        // SETUP cycle
        check("setup_pselx",   64'(pselx),   64'(exp_sel));
        check("setup_penable", 64'(penable), 64'd0);
        check("setup_paddr",   64'(paddr),   64'(addr));
        check("setup_pwrite",  64'(pwrite),  64'(wr));
        check("setup_pwdata",  64'(pwdata),  64'(wdata));
        check("setup_pstrb",   64'(pstrb),   wr ? 64'(strb) : 64'd0);
        check("setup_pprot",   64'(pprot),   64'(prot));
        // bus responses outside ACCESS must be ignored
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hBAD0_BAD0;
        n = (waits < 0) ? TOUT : waits + 1;
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            check("access_penable", 64'(penable), 64'd1);
            check("access_pselx",   64'(pselx),   64'(exp_sel));
            check("access_paddr",   64'(paddr),   64'(addr));
            pready  = (waits >= 0 && i == waits);
            pslverr = err;
            prdata  = rd;
        end
        @(negedge pclk);
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        check("resp_valid",   64'(rsp_valid), 64'd1);
        check("resp_pselx",   64'(pselx),     64'd0);
        check("resp_penable", 64'(penable),   64'd0);
        check("resp_paddr",   64'(paddr),     64'(addr));
    endtask

    // stimulus
    initial begin
        int gap;
        checks    = 0;
        failures  = 0;
        preset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b0;

        // reset state
        check("reset_bus",   64'({pselx, penable, pwrite, paddr}), 64'd0);
        check("reset_data",  64'({pwdata, pstrb, pprot}),          64'd0);
        check("reset_rsp",   64'({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, rsp_wait_states}), 64'd0);
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_state", 64'(fsm_state), 64'd0);

        // write to slave 2, no wait states
        do_xfer(1'b1, 32'h24, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'h0, 1'b0,
                4'b0100, {32'h0, 1'b0, 1'b0, 8'd0}, gap);
        // read from slave 0 with three wait states
        do_xfer(1'b0, 32'h05, 32'h1111_2222, 4'hF, 3'b001, 3, 32'h1234_5678, 1'b0,
                4'b0001, {32'h1234_5678, 1'b0, 1'b0, 8'd3}, gap);
        // decode miss
        do_xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 0, 32'h0, 1'b0,
                4'b0000, {32'h0, 1'b1, 1'b0, 8'd0}, gap);
        // timeout on slave 3
        do_xfer(1'b0, 32'h38, 32'h0, 4'h0, 3'b100, -1, 32'h5555_AAAA, 1'b0,
                4'b1000, {32'h0, 1'b1, 1'b1, 8'd16}, gap);
        // slave error on a write, one wait state
        do_xfer(1'b1, 32'h1C, 32'h0BAD_F00D, 4'h3, 3'b011, 1, 32'h0, 1'b1,
                4'b0010, {32'h0, 1'b1, 1'b0, 8'd1}, gap);
        // back-to-back read, issued during the previous response cycle
        do_xfer(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 0, 32'hA5A5_0F0F, 1'b0,
                4'b0010, {32'hA5A5_0F0F, 1'b0, 1'b0, 8'd0}, gap);
        check("b2b_accept_gap", 64'(gap), 64'd1);

        // reset during ACCESS: no response, bus back to reset values
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h20;
        req_prot  = 3'b111;
        gap = 0;
        while (!req_ready && gap < 50) begin
            @(negedge pclk);
            gap++;
        end
        @(negedge pclk);
        req_valid = 1'b0;
        repeat (2) @(negedge pclk);
        check("pre_reset_penable", 64'(penable), 64'd1);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        check("midreset_bus",   64'({pselx, penable, pwrite, paddr}), 64'd0);
        check("midreset_data",  64'({pwdata, pstrb, pprot}),          64'd0);
        check("midreset_rsp",   64'(rsp_valid), 64'd0);
        check("midreset_ready", 64'(req_ready), 64'd1);

        // normal transfer after reset
        do_xfer(1'b0, 32'h30, 32'h0, 4'hF, 3'b000, 2, 32'hCAFE_F00D, 1'b0,
                4'b1000, {32'hCAFE_F00D, 1'b0, 1'b0, 8'd2}, gap);

        repeat (4) @(negedge pclk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
Single-outstanding APB master controller between an internal valid/ready command port and the APB bus of NO_OF_SLAVES slaves. Decodes each request address to a one-hot pselx and runs the IDLE/SETUP/ACCESS sequence. Counts wait states, enforces a pready timeout and returns one response per request, carrying read data, pslverr and a timeout flag. Sits in the APB master agent's RTL model, driving the same pselx/pprot/pstrb signals the testbench transactions describe.

Parameters:
NO_OF_SLAVES, 1, number of slaves / width of pselx (1..16)
ADDRESS_WIDTH, 32, paddr width
DATA_WIDTH, 32, pwdata/prdata width (8, 16 or 32)
SLAVE_SPAN, 16, bytes decoded per slave (power of two); slave i owns [i*SLAVE_SPAN, (i+1)*SLAVE_SPAN-1]
TIMEOUT_CYCLES, 16, maximum wait states tolerated in ACCESS before abort (>=1)

Ports:
pclk  in  1  clock, rising edge
preset  in  1  synchronous, active-high reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid & req_ready
req_write  in  1  1=WRITE, 0=READ
req_addr  in  ADDRESS_WIDTH  target address
req_wdata  in  DATA_WIDTH  write data
req_strb  in  DATA_WIDTH/8  write byte strobes
req_prot  in  3  protection type
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data (0 for writes, errors, timeouts)
rsp_slverr  out  1  slave error, decode miss or timeout
rsp_timeout  out  1  transfer aborted by timeout
rsp_wait_states  out  8  wait states observed (saturates at 255)
pselx  out  NO_OF_SLAVES  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDRESS_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes (driven 0 on reads)
pprot  out  3  APB protection
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Reset (pclk edge with preset=1): state IDLE. pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, rsp_wait_states=0, wait counter=0. preset overrides all other activity.
- Reset mid-transfer: pselx/penable drop on the next edge. The aborted request gets no response.
- FSM states: IDLE, SETUP, ACCESS, RESP. req_ready=1 only in IDLE (combinational from state).
- IDLE: on accept, register write, addr, wdata, strb (0 if read) and prot into the APB outputs. idx = req_addr / SLAVE_SPAN. If idx < NO_OF_SLAVES, go to SETUP with pselx = 1<<idx. Otherwise (decode miss) go to RESP with slverr=1 and no APB activity.
- SETUP: pselx set, penable=0, counter cleared. Next state is ACCESS unconditionally.
- ACCESS: penable=1.
  - pready=1: capture prdata (reads only) and pslverr, go to RESP.
  - pready=0: counter+1. When the counter reaches TIMEOUT_CYCLES with pready still 0, go to RESP with slverr=1 and timeout=1.
- Leaving ACCESS (on either exit) clears pselx and penable on the same edge.
- RESP: rsp_valid=1 for exactly one cycle with the captured fields, then IDLE. The rsp_* fields hold their values until the next RESP. rsp_valid has no backpressure.
- paddr, pwrite, pwdata, pstrb and pprot are stable from SETUP through the end of ACCESS and hold their values in RESP/IDLE.
- Latency: accept at edge T, SETUP T+1, ACCESS T+2. With zero wait states, rsp_valid is high in T+3 and the next accept is possible in T+4. Each wait state adds one cycle.
- Wait counter: internal width clog2(TIMEOUT_CYCLES+1). rsp_wait_states = min(counter, 255).
- pready and pslverr are ignored outside ACCESS. The controller never asserts more than one pselx bit.

Test Plan:
- Write, NO_OF_SLAVES=4, addr=0x24, wdata=0xDEADBEEF, strb=0xF, pready tied 1 -> pselx=4'b0100 in SETUP/ACCESS, penable only in ACCESS, rsp_valid 3 cycles after accept, slverr=0, wait_states=0.
- Read, addr=0x05, pready low 3 cycles, prdata=0x12345678 -> rsp_rdata=0x12345678, wait_states=3, paddr stable throughout.
- Decode miss, addr=0x40 with 4 slaves -> pselx never asserted, rsp_valid 1 cycle after accept, slverr=1, timeout=0.
- Timeout, TIMEOUT_CYCLES=16, pready held 0 -> abort after 16 ACCESS wait cycles, slverr=1, timeout=1, rdata=0, pselx=0 afterwards.
- pslverr=1 with pready on a write -> rsp_slverr=1, timeout=0. Back-to-back request accepted in the cycle after RESP.
- preset asserted during ACCESS -> all outputs at reset values next edge, no rsp_valid, next request completes normally.
